ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_pkg.sv | 49 ++++
 rtl/hex_to_seg.sv | 32 +++
 rtl/ssd_scan_driver.sv | 143 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are gfedcba, active-low.
package ssd_pkg;

    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam int DEFAULT_BLANK_CYC   = 8;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] GLYPH_G     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Comparator flags are {gt, eq, lt}; anything not one-hot is shown as a dash.
    function automatic logic [6:0] cmp_glyph(input logic [2:0] cmp);
        logic [6:0] glyph;
        glyph = GLYPH_DASH;
        case (cmp)
            3'b100:  glyph = GLYPH_G;
            3'b010:  glyph = GLYPH_E;
            3'b001:  glyph = GLYPH_L;
            default: glyph = GLYPH_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver for ALU result/carry/compare flags.
// Optional macro SSD_LEADING_ZERO_BLANK_EN suppresses digit 1 when the high nibble is zero.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int BLANK_CYC   = DEFAULT_BLANK_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] result,
    input  logic       carry,
    input  logic [2:0] cmp,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;

    logic [7:0] result_reg;
    logic       carry_reg;
    logic [2:0] cmp_reg;
    logic       valid_reg;

    logic [3:0] an_reg, an_next;
    logic [6:0] seg_reg, seg_next;
    logic       dp_reg, dp_next;

    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic [3:0] an_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            carry_reg  <= 1'b0;
            cmp_reg    <= '0;
            valid_reg  <= 1'b0;
        end else if (load) begin
            result_reg <= result;
            carry_reg  <= carry;
            cmp_reg    <= cmp;
            valid_reg  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            an_reg    <= 4'b1111;
            seg_reg   <= GLYPH_BLANK;
            dp_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    // Index advances as SHOW ends; the 2-bit counter wraps 3->0 on its own.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        idx_next   = idx_reg;
        case (state_reg)
            ST_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = idx_reg + 2'd1;
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        nibble = 4'h0;
        case (idx_next)
            2'd0:    nibble = result_reg[3:0];
            2'd1:    nibble = result_reg[7:4];
            default: nibble = {3'b000, carry_reg};
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .hex (nibble),
        .seg (hex_seg)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_onehot[gi] = (idx_next != 2'(gi));
        end
    endgenerate

    // Outputs are registered from the next state so the anodes line up with
    // the FSM slots, while data comes from the hold registers already latched.
    always_comb begin
        an_next  = 4'b1111;
        seg_next = GLYPH_BLANK;
        dp_next  = 1'b1;
        if (state_next == ST_SHOW && valid_reg) begin
            an_next  = an_onehot;
            seg_next = (idx_next == 2'd3) ? cmp_glyph(cmp_reg) : hex_seg;
            dp_next  = !(idx_next == 2'd2 && carry_reg);
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (idx_next == 2'd1 && result_reg[7:4] == 4'h0) begin
                an_next  = 4'b1111;
                seg_next = GLYPH_BLANK;
            end
`else
`endif
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver with REFRESH_DIV=4, BLANK_CYC=2.
module tb_ssd_scan_driver;

    localparam int RD = 4;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] result = 8'h00;
    logic       carry = 1'b0;
    logic [2:0] cmp = 3'b000;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int failures = 0;
    int blank_carry = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         blank;
    } slot_t;

    slot_t exp_q[$];

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    ssd_scan_driver #(
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .result (result),
        .carry  (carry),
        .cmp    (cmp),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic slot_t model(input int d, input logic [7:0] r, input logic c,
                                    input logic [2:0] m);
        slot_t s;
        s.an    = 4'b1111;
        s.an[d] = 1'b0;
        s.dp    = 1'b1;
        s.blank = BC;
        s.seg   = 7'h7F;
        case (d)
            0: s.seg = hex_tab[r[3:0]];
            1: s.seg = hex_tab[r[7:4]];
            2: begin
                s.seg = c ? 7'h79 : 7'h40;
                s.dp  = !c;
            end
            default: begin
                case (m)
                    3'b100:  s.seg = 7'h42;
                    3'b010:  s.seg = 7'h06;
                    3'b001:  s.seg = 7'h47;
                    default: s.seg = 7'h3F;
                endcase
            end
        endcase
        return s;
    endfunction

    function automatic void push_scan(input logic [7:0] r, input logic c, input logic [2:0] m);
        bit skip1;
        skip1 = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        skip1 = (r[7:4] == 4'h0);
`endif
        for (int d = 0; d < 4; d++) begin
            slot_t s;
            s = model(d, r, c, m);
            if (d == 2 && skip1) s.blank = 2 * BC + RD;
            if (!(d == 1 && skip1)) exp_q.push_back(s);
        end
    endfunction

    function automatic int digit_of(input logic [3:0] a);
        int d;
        d = 0;
        case (a)
            4'b1101: d = 1;
            4'b1011: d = 2;
            4'b0111: d = 3;
            default: d = 0;
        endcase
        return d;
    endfunction

    // Monitor: records one lit slot (the blank run before it and the lit run itself).
    task automatic get_slot(output logic [3:0] a, output logic [6:0] s, output logic d,
                            output int len, output int blank, output bit stable);
        int guard;
        guard  = 0;
        blank  = blank_carry;
        len    = 0;
        stable = 1'b1;
        @(negedge clk);
        while (an === 4'b1111 && guard < 200) begin
            blank++;
            guard++;
            @(negedge clk);
        end
        a = an;
        s = seg;
        d = dp;
        while (an === a && guard < 200) begin
            len++;
            if (seg !== s || dp !== d) stable = 1'b0;
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL slot_timeout: got no complete slot in 200 cycles, want one");
        end
        blank_carry = (an === 4'b1111) ? 1 : 0;
    endtask

    task automatic sync_to(input logic [3:0] target);
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        int         len, blank, n;
        bit         stable;
        n = 0;
        a = 4'b1111;
        while (a !== target && n < 12) begin
            get_slot(a, s, d, len, blank, stable);
            n++;
        end
        if (a !== target) begin
            checks++;
            failures++;
            $display("FAIL sync: got an=%b, want an=%b", a, target);
        end
    endtask

    task automatic do_load(input logic [7:0] r, input logic c, input logic [2:0] m);
        result = r;
        carry  = c;
        cmp    = m;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            result = 8'($urandom);
            carry  = 1'($urandom);
            cmp    = 3'($urandom);
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
                failures++;
                $display("FAIL no_load_blank cycle %0d: got an=%b seg=%b dp=%b, want 1111 1111111 1",
                         i, an, seg, dp);
            end
        end
        $display("reset: 48 idle cycles observed");
    endtask

    task automatic test_pattern(input string name, input logic [7:0] r, input logic c,
                                input logic [2:0] m);
        slot_t      e;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        int         len, blank;
        bit         stable;
        do_load(r, c, m);
        sync_to(4'b0111);
        push_scan(r, c, m);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_slot(a, s, d, len, blank, stable);
            checks++;
            if ({a, s, d} !== {e.an, e.seg, e.dp}) begin
                failures++;
                $display("FAIL %s glyph: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         name, a, s, d, e.an, e.seg, e.dp);
            end
            checks++;
            if (len !== RD || blank !== e.blank || stable !== 1'b1) begin
                failures++;
                $display("FAIL %s timing: got len=%0d blank=%0d stable=%0d, want len=%0d blank=%0d stable=1",
                         name, len, blank, stable, RD, e.blank);
            end
            $display("slot %s: an=%b seg=%b dp=%b len=%0d blank=%0d", name, a, s, d, len, blank);
        end
    endtask

    // Unloaded input changes must not show; a load in BLANK captures without shifting timing.
    task automatic test_hold();
        slot_t      e;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        int         len, blank;
        bit         stable;
        @(negedge clk);
        result = 8'hFF;
        carry  = 1'b1;
        cmp    = 3'b001;
        sync_to(4'b0111);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                push_scan(8'hA5, 1'b0, 3'b110);
                push_scan(8'hA5, 1'b0, 3'b110);
            end else begin
                do_load(8'h3C, 1'b0, 3'b001);
                push_scan(8'h3C, 1'b0, 3'b001);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                get_slot(a, s, d, len, blank, stable);
                checks++;
                if ({a, s, d} !== {e.an, e.seg, e.dp}) begin
                    failures++;
                    $display("FAIL hold_p%0d glyph: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                             phase, a, s, d, e.an, e.seg, e.dp);
                end
                checks++;
                if (len !== RD || blank !== e.blank || stable !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_p%0d timing: got len=%0d blank=%0d stable=%0d, want len=%0d blank=%0d stable=1",
                             phase, len, blank, stable, RD, e.blank);
                end
                $display("slot hold_p%0d: digit=%0d an=%b seg=%b dp=%b len=%0d blank=%0d",
                         phase, digit_of(a), a, s, d, len, blank);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        sync_to(4'b1101);
        n = 0;
        while (an !== 4'b1011 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (an !== 4'b1011) begin
            failures++;
            $display("FAIL mid_show_digit2: got an=%b, want 1011", an);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL async_reset: got an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
        end
        $display("reset mid digit2: an=%b seg=%b dp=%b", an, seg, dp);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b1111) begin
                failures++;
                $display("FAIL valid_cleared cycle %0d: got an=%b, want 1111", i, an);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_load(8'h7B, 1'b0, 3'b100);
        @(negedge clk);
        checks++;
        if (an !== 4'b1111) begin
            failures++;
            $display("FAIL resume_blank: got an=%b, want 1111", an);
        end
        @(negedge clk);
        checks++;
        if ({an, seg} !== {4'b1110, hex_tab[4'hB]}) begin
            failures++;
            $display("FAIL resume_digit0: got an=%b seg=%b, want an=1110 seg=%b", an, seg, hex_tab[4'hB]);
        end
        $display("resume after reset: an=%b seg=%b", an, seg);
    endtask

    initial begin
        test_reset();
        test_pattern("p2E", 8'h2E, 1'b0, 3'b010);
        test_pattern("p00", 8'h00, 1'b1, 3'b100);
        test_pattern("dash", 8'hA5, 1'b0, 3'b110);
        test_hold();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
